mem_axi_window: RTL

MEM_AXI_WINDOW -- requirements
Module: mem_axi_window

---
 rtl/mem_axi_pkg.sv | 28 ++
 rtl/axi_skid_buffer.sv | 37 +++
 rtl/mem_axi_window.sv | 98 +++++++++
 3 files changed

// File: rtl/mem_axi_pkg.sv
// mem_axi_pkg: shared address-channel payload, window default and counter sizing for mem_axi_window
package mem_axi_pkg;
  localparam int MAX_ID_W = 16;
  localparam logic [3:0] WINDOW_BASE_DEF = 4'h1;
  typedef struct packed {
    logic [31:0] addr;
    logic [MAX_ID_W-1:0] id;
    logic [2:0] size;
    logic [7:0] len;
    logic [1:0] burst;
    logic [3:0] cache;
    logic lock;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
  } addr_chan_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic addr_chan_t pack_ac(
    input logic [3:0] base, input logic [31:0] addr, input logic [MAX_ID_W-1:0] id,
    input logic [2:0] size, input logic [7:0] len, input logic [1:0] burst,
    input logic [3:0] cache, input logic lock, input logic [2:0] prot,
    input logic [3:0] qos, input logic [3:0] region);
    return '{addr: {base, addr[27:0]}, id: id, size: size, len: len, burst: burst,
             cache: cache, lock: lock, prot: prot, qos: qos, region: region};
  endfunction
endpackage

// File: rtl/axi_skid_buffer.sv
// axi_skid_buffer: 2-entry FIFO for a valid/ready channel; in_ready is registered and means "not full".
// Ports: clk, reset (async, active-high), in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module axi_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt, cnt_n;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign cnt_n = cnt + {1'b0, push} - {1'b0, pop};
  assign out_valid = cnt != 2'd0;
  assign out_data = mem[rp];
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      cnt <= cnt_n;
      in_ready <= cnt_n != 2'd2;
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
    end
  end
  always_ff @(posedge clk) if (push) mem[wp] <= in_data;
endmodule

// File: rtl/mem_axi_window.sv
// mem_axi_window: AXI4 core-to-PS bridge that remaps addresses into the DRAM window and caps outstanding bursts.
// Ports: clk, reset (async, active-high); s_* AXI4 slave from core; m_* AXI4 master to PS HP port;
// idle (buffers empty, counters zero); win_err sticky out-of-window flags {write, read}.
// Optional: define MEM_WINDOW_CHECK_EN to enable the out-of-window detector.
module mem_axi_window import mem_axi_pkg::*; #(
  parameter int ID_W = 6,
  parameter int DATA_W = 64,
  parameter int MAX_OUTSTANDING = 8,
  parameter logic [3:0] WINDOW_BASE = WINDOW_BASE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic s_ar_valid, output logic s_ar_ready, input logic [31:0] s_ar_addr, input logic [ID_W-1:0] s_ar_id,
  input  logic [2:0] s_ar_size, input logic [7:0] s_ar_len, input logic [1:0] s_ar_burst, input logic [3:0] s_ar_cache,
  input  logic s_ar_lock, input logic [2:0] s_ar_prot, input logic [3:0] s_ar_qos, input logic [3:0] s_ar_region,
  input  logic s_aw_valid, output logic s_aw_ready, input logic [31:0] s_aw_addr, input logic [ID_W-1:0] s_aw_id,
  input  logic [2:0] s_aw_size, input logic [7:0] s_aw_len, input logic [1:0] s_aw_burst, input logic [3:0] s_aw_cache,
  input  logic s_aw_lock, input logic [2:0] s_aw_prot, input logic [3:0] s_aw_qos, input logic [3:0] s_aw_region,
  input  logic s_w_valid, output logic s_w_ready, input logic [DATA_W-1:0] s_w_data,
  input  logic [DATA_W/8-1:0] s_w_strb, input logic s_w_last,
  output logic s_r_valid, input logic s_r_ready, output logic [DATA_W-1:0] s_r_data,
  output logic [ID_W-1:0] s_r_id, output logic [1:0] s_r_resp, output logic s_r_last,
  output logic s_b_valid, input logic s_b_ready, output logic [ID_W-1:0] s_b_id, output logic [1:0] s_b_resp,
  output logic m_ar_valid, input logic m_ar_ready, output logic [31:0] m_ar_addr, output logic [ID_W-1:0] m_ar_id,
  output logic [2:0] m_ar_size, output logic [7:0] m_ar_len, output logic [1:0] m_ar_burst, output logic [3:0] m_ar_cache,
  output logic m_ar_lock, output logic [2:0] m_ar_prot, output logic [3:0] m_ar_qos, output logic [3:0] m_ar_region,
  output logic m_aw_valid, input logic m_aw_ready, output logic [31:0] m_aw_addr, output logic [ID_W-1:0] m_aw_id,
  output logic [2:0] m_aw_size, output logic [7:0] m_aw_len, output logic [1:0] m_aw_burst, output logic [3:0] m_aw_cache,
  output logic m_aw_lock, output logic [2:0] m_aw_prot, output logic [3:0] m_aw_qos, output logic [3:0] m_aw_region,
  output logic m_w_valid, input logic m_w_ready, output logic [DATA_W-1:0] m_w_data,
  output logic [DATA_W/8-1:0] m_w_strb, output logic m_w_last,
  input  logic m_r_valid, output logic m_r_ready, input logic [DATA_W-1:0] m_r_data,
  input  logic [ID_W-1:0] m_r_id, input logic [1:0] m_r_resp, input logic m_r_last,
  input  logic m_b_valid, output logic m_b_ready, input logic [ID_W-1:0] m_b_id, input logic [1:0] m_b_resp,
  output logic idle,
  output logic [1:0] win_err
);
  localparam int CW = cnt_w(MAX_OUTSTANDING);
  addr_chan_t ar_in, ar_out, aw_in, aw_out;
  logic ar_buf_valid, aw_buf_valid, rd_full, wr_full, rd_inc, rd_dec, wr_inc, wr_dec, unused;
  logic [CW-1:0] rd_cnt, wr_cnt;
  // The remap happens before buffering so the stored upper nibble is already the window base.
  assign ar_in = pack_ac(WINDOW_BASE, s_ar_addr, MAX_ID_W'(s_ar_id), s_ar_size, s_ar_len, s_ar_burst,
                         s_ar_cache, s_ar_lock, s_ar_prot, s_ar_qos, s_ar_region);
  assign aw_in = pack_ac(WINDOW_BASE, s_aw_addr, MAX_ID_W'(s_aw_id), s_aw_size, s_aw_len, s_aw_burst,
                         s_aw_cache, s_aw_lock, s_aw_prot, s_aw_qos, s_aw_region);
  assign unused = ^{ar_out.id, aw_out.id, s_ar_addr[31:28], s_aw_addr[31:28]};
  axi_skid_buffer #(.W($bits(addr_chan_t))) u_ar_buf (
    .clk(clk), .reset(reset), .in_valid(s_ar_valid), .in_ready(s_ar_ready), .in_data(ar_in),
    .out_valid(ar_buf_valid), .out_ready(m_ar_ready & ~rd_full), .out_data(ar_out));
  axi_skid_buffer #(.W($bits(addr_chan_t))) u_aw_buf (
    .clk(clk), .reset(reset), .in_valid(s_aw_valid), .in_ready(s_aw_ready), .in_data(aw_in),
    .out_valid(aw_buf_valid), .out_ready(m_aw_ready & ~wr_full), .out_data(aw_out));
  assign rd_full = rd_cnt == CW'(MAX_OUTSTANDING);
  assign wr_full = wr_cnt == CW'(MAX_OUTSTANDING);
  assign m_ar_valid = ar_buf_valid & ~rd_full;
  assign m_aw_valid = aw_buf_valid & ~wr_full;
  assign {m_ar_addr, m_ar_id, m_ar_size, m_ar_len, m_ar_burst} =
         {ar_out.addr, ar_out.id[ID_W-1:0], ar_out.size, ar_out.len, ar_out.burst};
  assign {m_ar_cache, m_ar_lock, m_ar_prot, m_ar_qos, m_ar_region} =
         {ar_out.cache, ar_out.lock, ar_out.prot, ar_out.qos, ar_out.region};
  assign {m_aw_addr, m_aw_id, m_aw_size, m_aw_len, m_aw_burst} =
         {aw_out.addr, aw_out.id[ID_W-1:0], aw_out.size, aw_out.len, aw_out.burst};
  assign {m_aw_cache, m_aw_lock, m_aw_prot, m_aw_qos, m_aw_region} =
         {aw_out.cache, aw_out.lock, aw_out.prot, aw_out.qos, aw_out.region};
  assign {m_w_valid, m_w_data, m_w_strb, m_w_last, s_w_ready} = {s_w_valid, s_w_data, s_w_strb, s_w_last, m_w_ready};
  assign {s_r_valid, s_r_data, s_r_id, s_r_resp, s_r_last, m_r_ready} =
         {m_r_valid, m_r_data, m_r_id, m_r_resp, m_r_last, s_r_ready};
  assign {s_b_valid, s_b_id, s_b_resp, m_b_ready} = {m_b_valid, m_b_id, m_b_resp, s_b_ready};
  assign rd_inc = m_ar_valid & m_ar_ready;
  assign rd_dec = m_r_valid & s_r_ready & m_r_last;
  assign wr_inc = m_aw_valid & m_aw_ready;
  assign wr_dec = m_b_valid & s_b_ready;
  // Simultaneous issue and completion cancel; a completion at zero is ignored so the counters never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_inc & ~rd_dec) rd_cnt <= rd_cnt + CW'(1);
      else if (rd_dec & ~rd_inc & rd_cnt != '0) rd_cnt <= rd_cnt - CW'(1);
      if (wr_inc & ~wr_dec) wr_cnt <= wr_cnt + CW'(1);
      else if (wr_dec & ~wr_inc & wr_cnt != '0) wr_cnt <= wr_cnt - CW'(1);
    end
  end
  assign idle = ~ar_buf_valid & ~aw_buf_valid & rd_cnt == '0 & wr_cnt == '0;
`ifdef MEM_WINDOW_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) win_err <= '0;
    else begin
      if (s_ar_valid & s_ar_ready & |s_ar_addr[31:28]) win_err[0] <= 1'b1;
      if (s_aw_valid & s_aw_ready & |s_aw_addr[31:28]) win_err[1] <= 1'b1;
    end
  end
`else
  assign win_err = '0;
`endif
endmodule
